// File: rtl/demux_1_8_deser_v.sv
// rtl/demux_1_8_deser_v.sv - registered 1:8 demultiplexer/deserializer with valid/ready word output
module demux_1_8_deser_v #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mode,
  input  logic             i_a,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_sel_code,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_f,
  output logic [WIDTH-1:0] o_code,
  output logic             o_code_valid,
  input  logic             i_code_ready,
  output logic [2:0]       o_sel_cnt,
  output logic             o_overrun
);

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] staging, mask;
  logic [WIDTH-1:0] staging_upd, mask_upd, lane_oh, load_data;
  logic [2:0]       cnt, lane;
  logic             mode_r, boundary, cur_mode;
  logic             accept, done, slot_free, load_out;

  // At a word boundary the incoming i_mode already governs the first bit.
  always_comb begin
    boundary    = (state == FILL) && (mask == '0) && (cnt == 3'd0);
    cur_mode    = boundary ? i_mode : mode_r;
    accept      = i_valid & o_ready & ~i_clear;
    if (cur_mode)
      lane = MSB_FIRST ? (3'd7 - cnt) : cnt;
    else
      lane = i_sel_code;
    lane_oh     = 8'd1 << lane;
    staging_upd = i_a ? (staging | lane_oh) : (staging & ~lane_oh);
    mask_upd    = mask | lane_oh;
    done        = accept && (cur_mode ? (cnt == 3'd7) : (mask_upd == 8'hFF));
    slot_free   = ~o_code_valid | i_code_ready;
    load_out    = (done & slot_free) |
                  ((state == STALL) & i_code_ready & ~i_clear);
    load_data   = (state == STALL) ? staging : staging_upd;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      state <= FILL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_clear)
      state_nxt = FILL;
    else begin
      case (state)
        FILL:    if (done && !slot_free) state_nxt = STALL;
        STALL:   if (i_code_ready)       state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    o_ready   = i_rst_n & (state == FILL);
    o_sel_cnt = cnt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      staging      <= '0;
      mask         <= '0;
      cnt          <= 3'd0;
      mode_r       <= 1'b0;
      o_f          <= '0;
      o_code       <= '0;
      o_code_valid <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_f <= accept ? lane_oh : '0;
      if (i_valid && !o_ready)
        o_overrun <= 1'b1;
      if (boundary)
        mode_r <= i_mode;

      if (load_out) begin
        o_code       <= load_data;
        o_code_valid <= 1'b1;
      end else if (i_code_ready) begin
        o_code_valid <= 1'b0;
      end

      // A word that stalls keeps its full mask, so no new bits can land until it drains.
      if (i_clear || load_out) begin
        staging <= '0;
        mask    <= '0;
        cnt     <= 3'd0;
      end else if (accept) begin
        staging <= staging_upd;
        mask    <= mask_upd;
        if (cur_mode)
          cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux_1_8_deser_v.sv
// tb/tb_demux_1_8_deser_v.sv - table-driven and directed bench for demux_1_8_deser_v
module tb_demux_1_8_deser_v;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b1, a = 1'b0, valid = 1'b0, clr = 1'b0, cr = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       o_ready, o_code_valid, o_overrun;
  logic [7:0] o_f, o_code;
  logic [2:0] o_sel_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1_8_deser_v #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mode       (mode),
    .i_a          (a),
    .i_valid      (valid),
    .o_ready      (o_ready),
    .i_sel_code   (sel),
    .i_clear      (clr),
    .o_f          (o_f),
    .o_code       (o_code),
    .o_code_valid (o_code_valid),
    .i_code_ready (cr),
    .o_sel_cnt    (o_sel_cnt),
    .o_overrun    (o_overrun)
  );

  typedef struct {
    logic       mode, a, valid;
    logic [2:0] sel;
    logic       clr, cr;
    logic [7:0] f, code;
    logic       cv, rdy;
    logic [2:0] cnt;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic m, logic b, logic v, logic [2:0] s, logic c, logic r,
                              logic [7:0] f, logic [7:0] code, logic cv, logic rdy,
                              logic [2:0] cnt, logic ovr);
    vec_t t;
    t.mode = m; t.a = b; t.valid = v; t.sel = s; t.clr = c; t.cr = r;
    t.f = f; t.code = code; t.cv = cv; t.rdy = rdy; t.cnt = cnt; t.ovr = ovr;
    return t;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [7:0] f, logic [7:0] code, logic cv,
                           logic rdy, logic [2:0] cnt, logic ovr);
    chk({tag, ".f"},     o_f, f);
    chk({tag, ".code"},  o_code, code);
    chk({tag, ".cv"},    {7'd0, o_code_valid}, {7'd0, cv});
    chk({tag, ".ready"}, {7'd0, o_ready}, {7'd0, rdy});
    chk({tag, ".cnt"},   {5'd0, o_sel_cnt}, {5'd0, cnt});
    chk({tag, ".ovr"},   {7'd0, o_overrun}, {7'd0, ovr});
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic drive(logic m, logic b, logic v, logic [2:0] s, logic c, logic r);
    mode = m; a = b; valid = v; sel = s; clr = c; cr = r;
    @(posedge clk);
    #1;
  endtask

  task automatic seq_word(string tag, logic [7:0] w, logic r);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w[i], 1'b1, 3'd0, 1'b0, r);
      chk($sformatf("%s.f%0d", tag, i), o_f, 8'd1 << i);
    end
  endtask

  initial begin
    logic [7:0] w;

    // sequential word 1,0,1,1,0,0,1,0 -> 8'h4D, consumer always ready
    tbl.push_back(mk(1,1,1,0,0,1, 8'h01,8'h00,0,1,3'd1,0));
    tbl.push_back(mk(1,0,1,0,0,1, 8'h02,8'h00,0,1,3'd2,0));
    tbl.push_back(mk(1,1,1,0,0,1, 8'h04,8'h00,0,1,3'd3,0));
    tbl.push_back(mk(1,1,1,0,0,1, 8'h08,8'h00,0,1,3'd4,0));
    tbl.push_back(mk(1,0,1,0,0,1, 8'h10,8'h00,0,1,3'd5,0));
    tbl.push_back(mk(1,0,1,0,0,1, 8'h20,8'h00,0,1,3'd6,0));
    tbl.push_back(mk(1,1,1,0,0,1, 8'h40,8'h00,0,1,3'd7,0));
    tbl.push_back(mk(1,0,1,0,0,1, 8'h80,8'h4D,1,1,3'd0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 8'h00,8'h4D,0,1,3'd0,0));
    // addressed lanes 7,0,3,3(0 over 1),1,2,4,5,6 -> 8'hF7 on the 9th accept
    tbl.push_back(mk(0,1,1,7,0,1, 8'h80,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,0,0,1, 8'h01,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,3,0,1, 8'h08,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,0,1,3,0,1, 8'h08,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,1,0,1, 8'h02,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,2,0,1, 8'h04,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,4,0,1, 8'h10,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,5,0,1, 8'h20,8'h4D,0,1,3'd0,0));
    tbl.push_back(mk(0,1,1,6,0,1, 8'h40,8'hF7,1,1,3'd0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 8'h00,8'hF7,0,1,3'd0,0));

    drive(1,0,0,0,0,0);
    drive(1,0,0,0,0,0);
    check_all("reset", 8'h00, 8'h00, 0, 0, 3'd0, 0);
    rst_n = 1'b1;
    #1;
    chk("reset.ready_release", {7'd0, o_ready}, 8'h01);

    foreach (tbl[i]) begin
      drive(tbl[i].mode, tbl[i].a, tbl[i].valid, tbl[i].sel, tbl[i].clr, tbl[i].cr);
      check_all($sformatf("vec%0d", i), tbl[i].f, tbl[i].code, tbl[i].cv,
                tbl[i].rdy, tbl[i].cnt, tbl[i].ovr);
    end

    // back-to-back words with a stalled consumer
    seq_word("t3w1", 8'hA5, 1'b0);
    check_all("t3w1", 8'h80, 8'hA5, 1, 1, 3'd0, 0);
    seq_word("t3w2", 8'h3C, 1'b0);
    check_all("t3stall", 8'h80, 8'hA5, 1, 0, 3'd0, 0);
    drive(1,0,1,0,0,0);
    check_all("t3ovr", 8'h00, 8'hA5, 1, 0, 3'd0, 1);
    drive(1,0,0,0,0,1);
    check_all("t3rel", 8'h00, 8'h3C, 1, 1, 3'd0, 1);
    drive(1,0,0,0,0,1);
    check_all("t3drain", 8'h00, 8'h3C, 0, 1, 3'd0, 1);

    // clear with a same-cycle valid after 5 accepts
    for (int i = 0; i < 5; i++) drive(1,1,1,0,0,1);
    chk("t4.cnt5", {5'd0, o_sel_cnt}, 8'd5);
    drive(1,1,1,0,1,1);
    check_all("t4clr", 8'h00, 8'h3C, 0, 1, 3'd0, 1);
    seq_word("t4w", 8'h96, 1'b1);
    check_all("t4word", 8'h80, 8'h96, 1, 1, 3'd0, 1);

    // mode drops to addressed after 3 sequential accepts
    w = 8'hD3;
    for (int i = 0; i < 3; i++) drive(1, w[i], 1, 3'd0, 0, 1);
    chk("t5.cnt3", {5'd0, o_sel_cnt}, 8'd3);
    for (int i = 3; i < 8; i++) begin
      drive(0, w[i], 1, 3'd7, 0, 1);
      chk($sformatf("t5.f%0d", i), o_f, 8'd1 << i);
    end
    check_all("t5word", 8'h80, 8'hD3, 1, 1, 3'd0, 1);
    drive(0,1,1,3'd5,0,1);
    check_all("t5addr", 8'h20, 8'hD3, 0, 1, 3'd0, 1);
    drive(1,0,0,0,1,1);
    check_all("t5clr", 8'h00, 8'hD3, 0, 1, 3'd0, 1);

    // reset while stalled with a held word
    seq_word("t6w1", 8'h11, 1'b0);
    seq_word("t6w2", 8'h22, 1'b0);
    check_all("t6stall", 8'h80, 8'h11, 1, 0, 3'd0, 1);
    rst_n = 1'b0;
    drive(1,0,1,0,0,0);
    check_all("t6rst", 8'h00, 8'h00, 0, 0, 3'd0, 0);
    rst_n = 1'b1;
    #1;
    chk("t6.ready_release", {7'd0, o_ready}, 8'h01);
    drive(1,0,0,0,0,0);
    check_all("t6post", 8'h00, 8'h00, 0, 1, 3'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
